// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: shares the single-port program/graphics ROM RAM between the
// mist_io SPI ROM download (ioctl writes) and the galaxian core CPU read port,
// and holds the core in reset while a download is in progress and for
// HOLD_CYCLES clk_sys cycles after it ends (or after reset release).
//
// Optional build macro: ROM_DL_CKSUM_EN adds dl_cksum, the modulo-256 sum of
// every byte actually written to the RAM since the last download start.
module rom_dl_arbiter #(
  parameter int unsigned AW          = 16,
  parameter int unsigned ROM_SIZE    = 32'h8000,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter logic [7:0]  DL_INDEX    = 8'd0
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_rd_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_rd_ack,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  output logic          core_reset,
  output logic          dl_busy,
  output logic          dl_overrun
`ifdef ROM_DL_CKSUM_EN
  ,
  output logic [7:0]    dl_cksum
`endif
);

  localparam int unsigned CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_ACK
  } state_e;

  state_e        state_q;

  // one-entry download write buffer
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic          pend_q,     pend_d;
  logic          ovr_q,      ovr_d;

  // post-download core reset hold counter
  logic [CW-1:0] hold_q,     hold_d;
  logic          core_reset_q;
  logic          busy_q;

  // registered RAM / CPU side outputs
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_din_q;
  logic          mem_we_q;
  logic          ack_q;
  logic [7:0]    dout_q;

  logic          capture;
  logic          clearing;
  logic          busy_term;
  logic [AW-1:0] wr_addr_eff;
  logic [7:0]    wr_data_eff;

  // Write capture, buffer/overrun next state, hold counter next state.
  always_comb begin
    capture   = ioctl_wr && (ioctl_index == DL_INDEX) && (32'(ioctl_addr) < ROM_SIZE);
    clearing  = (state_q == S_WR);

    // a capture in the same cycle as the WR clear wins
    pend_d     = capture | (pend_q & ~clearing);
    ovr_d      = ovr_q | (capture & pend_q & ~clearing);
    buf_addr_d = capture ? ioctl_addr : buf_addr_q;
    buf_data_d = capture ? ioctl_dout : buf_data_q;

    // When a strobe lands in the very cycle the buffer is launched into WR,
    // launch the new byte so that WR writes what the buffer will hold.
    wr_addr_eff = capture ? ioctl_addr : buf_addr_q;
    wr_data_eff = capture ? ioctl_dout : buf_data_q;

    busy_term = ioctl_download | pend_q | (hold_q != '0);

    if (ioctl_download || pend_q) begin
      hold_d = HOLD_LD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - CW'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Buffer, sticky overrun, hold counter and registered core reset / busy.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      pend_q       <= 1'b0;
      ovr_q        <= 1'b0;
      hold_q       <= HOLD_LD;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      pend_q       <= pend_d;
      ovr_q        <= ovr_d;
      hold_q       <= hold_d;
      core_reset_q <= busy_term;
      busy_q       <= busy_term;
    end
  end

  // Arbitration FSM: writes before reads, reads never aborted.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      mem_we_q <= 1'b0;
      ack_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            state_q    <= S_WR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_addr_eff;
            mem_din_q  <= wr_data_eff;
          end else if (cpu_rd_req) begin
            state_q    <= S_RD;
            mem_addr_q <= cpu_addr;
          end
        end
        S_WR: begin
          state_q <= S_IDLE;
        end
        S_RD: begin
          state_q <= S_ACK;
          ack_q   <= 1'b1;
        end
        S_ACK: begin
          dout_q <= mem_dout;
          // a write buffered during the read goes straight out after ACK
          if (pend_q) begin
            state_q    <= S_WR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_addr_eff;
            mem_din_q  <= wr_data_eff;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign cpu_rd_ack = ack_q;
  // RAM data only arrives in the ACK cycle, so it is bypassed onto cpu_dout
  // then and held from dout_q afterwards.
  assign cpu_dout   = ack_q ? mem_dout : dout_q;
  assign core_reset = core_reset_q;
  assign dl_busy    = busy_q;
  assign dl_overrun = ovr_q;

`ifdef ROM_DL_CKSUM_EN
  logic       dl_prev_q;
  logic [7:0] cksum_q;

  // Running byte sum of RAM writes, restarted on each download start.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev_q <= 1'b0;
      cksum_q   <= '0;
    end else begin
      dl_prev_q <= ioctl_download;
      if (ioctl_download && !dl_prev_q) begin
        cksum_q <= '0;
      end else if (mem_we_q) begin
        cksum_q <= cksum_q + mem_din_q;
      end
    end
  end

  assign dl_cksum = cksum_q;
`else
  // checksum disabled: no extra port or state
`endif

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Scoreboard bench for rom_dl_arbiter: stimulus pushes expected RAM writes and
// CPU read responses into queues, a negedge monitor pops and compares them.
module tb_rom_dl_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned HOLD  = 1024;
  localparam int unsigned ROMSZ = 32'h8000;

  logic          clk_sys        = 1'b0;
  logic          reset          = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index    = 8'd0;
  logic          ioctl_wr       = 1'b0;
  logic [AW-1:0] ioctl_addr     = '0;
  logic [7:0]    ioctl_dout     = '0;
  logic          cpu_rd_req     = 1'b0;
  logic [AW-1:0] cpu_addr       = '0;
  logic          cpu_rd_ack;
  logic [7:0]    cpu_dout;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_dout;
  logic          core_reset;
  logic          dl_busy;
  logic          dl_overrun;
`ifdef ROM_DL_CKSUM_EN
  logic [7:0]    dl_cksum;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            at;
  } wr_exp_t;

  typedef struct {
    logic [7:0] data;
    int         at;
  } rd_exp_t;

  int            checks   = 0;
  int            errors   = 0;
  int            cyc      = 0;
  int            we_seen  = 0;
  int            ack_seen = 0;
  wr_exp_t       wq[$];
  rd_exp_t       rq[$];
  logic [AW-1:0] wlist[$];
  logic [7:0]    shadow [0:65535];
  logic [7:0]    ram    [0:65535];
  logic [7:0]    cks_model = 8'd0;

  rom_dl_arbiter #(
    .AW(AW),
    .ROM_SIZE(ROMSZ),
    .HOLD_CYCLES(HOLD),
    .DL_INDEX(8'd0)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .cpu_rd_req(cpu_rd_req),
    .cpu_addr(cpu_addr),
    .cpu_rd_ack(cpu_rd_ack),
    .cpu_dout(cpu_dout),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_we(mem_we),
    .mem_dout(mem_dout),
    .core_reset(core_reset),
    .dl_busy(dl_busy),
    .dl_overrun(dl_overrun)
`ifdef ROM_DL_CKSUM_EN
    ,
    .dl_cksum(dl_cksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 8));
  endfunction

  // single-port synchronous RAM, one-cycle read latency, preloaded
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = pat(i);
    ram[16'h1234] = 8'h5A;
    forever begin
      @(posedge clk_sys);
      mem_dout <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every mem_we pulse and every ack is popped against the scoreboard
  always @(negedge clk_sys) begin
    wr_exp_t we;
    rd_exp_t re;
    if (!reset) begin
      if (mem_we) begin
        we_seen++;
        chk("write expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          we = wq.pop_front();
          chk("write addr", 32'(mem_addr), 32'(we.addr));
          chk("write data", 32'(mem_din), 32'(we.data));
          chk("write cycle", 32'(cyc), 32'(we.at));
        end
      end
      if (cpu_rd_ack) begin
        ack_seen++;
        chk("ack expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          chk("read data", 32'(cpu_dout), 32'(re.data));
          chk("ack cycle", 32'(cyc), 32'(re.at));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic bit accepted(input logic [7:0] idx, input logic [AW-1:0] a);
    return (idx == 8'd0) && (32'(a) < ROMSZ);
  endfunction

  // one strobe issued from an idle arbiter; returns with the arbiter idle again
  task automatic dl_write(input logic [7:0] idx, input logic [AW-1:0] a, input logic [7:0] d);
    if (accepted(idx, a)) begin
      wq.push_back('{a, d, cyc + 2});
      shadow[a] = d;
      cks_model = cks_model + d;
      wlist.push_back(a);
    end
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_rd_ack && n < 8);
    chk("ack within budget", 32'(cpu_rd_ack), 32'd1);
    cpu_rd_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rq.push_back('{shadow[a], cyc + 2});
    cpu_addr   = a;
    cpu_rd_req = 1'b1;
    wait_ack();
    tick();
  endtask

  // core_reset must stay high exactly HOLD cycles after its last cause ends
  task automatic hold_check(input string name);
    int hi = 0;
    int first_low = 0;
    int mism = 0;
    for (int i = 1; i <= int'(HOLD) + 80; i++) begin
      tick();
      if (core_reset === 1'b1) hi++;
      else if (first_low == 0) first_low = i;
      if (dl_busy !== core_reset) mism++;
    end
    chk({name, " core_reset high cycles"}, 32'(hi), HOLD);
    chk({name, " core_reset first low"}, 32'(first_low), HOLD + 1);
    chk({name, " dl_busy tracks core_reset"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int n0;
    int we0;
    int ack0;
    logic [7:0]    idx;
    logic [AW-1:0] a;

    for (int i = 0; i < 65536; i++) shadow[i] = pat(i);
    shadow[16'h1234] = 8'h5A;

    // reset state
    repeat (3) tick();
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_din", 32'(mem_din), 32'd0);
    chk("reset cpu_rd_ack", 32'(cpu_rd_ack), 32'd0);
    chk("reset cpu_dout", 32'(cpu_dout), 32'd0);
    chk("reset dl_overrun", 32'(dl_overrun), 32'd0);
    chk("reset core_reset", 32'(core_reset), 32'd1);
    chk("reset dl_busy", 32'(dl_busy), 32'd1);
    reset = 1'b0;
    hold_check("after reset");

    // three-byte download
    ioctl_download = 1'b1;
    cks_model      = 8'd0;
    tick();
    tick();
    chk("core_reset during download", 32'(core_reset), 32'd1);
    chk("dl_busy during download", 32'(dl_busy), 32'd1);
    dl_write(8'd0, 16'h0000, 8'hA5);
    tick();
    dl_write(8'd0, 16'h0001, 8'h3C);
    tick();
    dl_write(8'd0, 16'h7FFF, 8'hFF);
    tick();
`ifdef ROM_DL_CKSUM_EN
    chk("checksum three bytes", 32'(dl_cksum), 32'(cks_model));
`endif
    ioctl_download = 1'b0;
    hold_check("after download");

    // ignored strobes: out of range and wrong index
    we0 = we_seen;
    dl_write(8'd0, 16'h8000, 8'h11);
    chk("out-of-range leaves busy low", 32'(dl_busy), 32'd0);
    dl_write(8'd1, 16'h0010, 8'h22);
    chk("wrong index leaves busy low", 32'(dl_busy), 32'd0);
    chk("ignored strobes write nothing", 32'(we_seen - we0), 32'd0);

    // CPU read, then held request re-issues
    ack0 = ack_seen;
    n0   = cyc;
    rq.push_back('{8'h5A, n0 + 2});
    rq.push_back('{8'h5A, n0 + 5});
    cpu_addr   = 16'h1234;
    cpu_rd_req = 1'b1;
    repeat (5) tick();
    cpu_rd_req = 1'b0;
    repeat (3) tick();
    chk("back-to-back ack count", 32'(ack_seen - ack0), 32'd2);
    chk("cpu_dout held", 32'(cpu_dout), 32'h5A);

    // write during read to the same address: read returns the old byte
    n0 = cyc;
    rq.push_back('{shadow[16'h1234], n0 + 2});
    cpu_addr   = 16'h1234;
    cpu_rd_req = 1'b1;
    tick();
    wq.push_back('{16'h1234, 8'hC3, n0 + 3});
    shadow[16'h1234] = 8'hC3;
    cks_model = cks_model + 8'hC3;
    ioctl_index = 8'd0;
    ioctl_addr  = 16'h1234;
    ioctl_dout  = 8'hC3;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    cpu_rd_req = 1'b0;
    repeat (3) tick();
    do_read(16'h1234);

    // overrun: strobes in RD and ACK, only the second byte lands
    chk("overrun clear before", 32'(dl_overrun), 32'd0);
    n0 = cyc;
    rq.push_back('{shadow[16'h2000], n0 + 2});
    cpu_addr   = 16'h2000;
    cpu_rd_req = 1'b1;
    tick();
    ioctl_index = 8'd0;
    ioctl_addr  = 16'h0100;
    ioctl_dout  = 8'h11;
    ioctl_wr    = 1'b1;
    tick();
    chk("overrun after one strobe", 32'(dl_overrun), 32'd0);
    cpu_rd_req = 1'b0;
    wq.push_back('{16'h0101, 8'h22, n0 + 3});
    shadow[16'h0101] = 8'h22;
    cks_model = cks_model + 8'h22;
    ioctl_addr = 16'h0101;
    ioctl_dout = 8'h22;
    tick();
    ioctl_wr = 1'b0;
    chk("overrun set", 32'(dl_overrun), 32'd1);
    tick();
    tick();
    do_read(16'h0100);
    do_read(16'h0101);

    // randomized download then randomized reads
    ioctl_download = 1'b1;
    cks_model      = 8'd0;
    tick();
    for (int k = 0; k < 40; k++) begin
      idx = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
      a   = 16'($urandom_range(0, 32'h9FFF));
      dl_write(idx, a, 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    ioctl_download = 1'b0;
    tick();
`ifdef ROM_DL_CKSUM_EN
    chk("checksum random download", 32'(dl_cksum), 32'(cks_model));
`endif
    for (int k = 0; k < 40; k++) begin
      if (wlist.size() != 0 && $urandom_range(0, 1) == 1)
        a = wlist[$urandom_range(0, wlist.size() - 1)];
      else
        a = 16'($urandom);
      do_read(a);
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("overrun stays sticky", 32'(dl_overrun), 32'd1);

    // reset in the middle of a RAM write
    we0 = we_seen;
    ioctl_index = 8'd0;
    ioctl_addr  = 16'h3000;
    ioctl_dout  = 8'h77;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    chk("mem_we in flight", 32'(mem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mem_we drops on reset", 32'(mem_we), 32'd0);
    chk("core_reset on reset", 32'(core_reset), 32'd1);
    chk("overrun cleared by reset", 32'(dl_overrun), 32'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("pending write lost", 32'(we_seen - we0), 32'd0);
    do_read(16'h3000);
    tick();

    chk("write queue drained", 32'(wq.size()), 32'd0);
    chk("read queue drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
